// File: rtl/array_feeder_if.sv
// Handshake bundle between the upstream producer, array_feeder and the downstream consumer.
// slave: the feeder's view. master: the environment that produces and consumes words.
interface array_feeder_if;
  logic signed [31:0] src_in;
  logic               src_in_sync;
  logic               src_in_notify;
  logic signed [31:0] m_out;
  logic               m_out_sync;
  logic               m_out_notify;

  modport slave (
    input  src_in,
    input  src_in_sync,
    input  m_out_sync,
    output src_in_notify,
    output m_out,
    output m_out_notify
  );

  modport master (
    output src_in,
    output src_in_sync,
    output m_out_sync,
    input  src_in_notify,
    input  m_out,
    input  m_out_notify
  );
endinterface

// File: rtl/array_feeder.sv
// array_feeder: collects DEPTH signed words from the producer into a small array, then
// replays them in order to the consumer. The two phases alternate and never overlap.
// Optional feature: define ARRAY_FEEDER_SUM_EN to append a wrapped 32-bit checksum word
// after the last array word of each frame.
module array_feeder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  array_feeder_if.slave  bus_io
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  typedef enum logic {StFill, StDrain} state_e;

  state_e             state_q;
  logic [IdxW-1:0]    wr_idx_q;
  logic [IdxW-1:0]    rd_idx_q;
  logic               src_notify_q;
  logic               m_notify_q;
  logic signed [31:0] m_out_q;
  logic signed [31:0] arr_q [DEPTH];

  logic               in_xfer;
  logic               out_xfer;
  logic [IdxW-1:0]    rd_idx_d;
  logic               rd_last;
  logic               last_word;
  logic signed [31:0] next_word;

  assign in_xfer  = src_notify_q & bus_io.src_in_sync;
  assign out_xfer = m_notify_q & bus_io.m_out_sync;
  assign rd_last  = (rd_idx_q == LastIdx);
  assign rd_idx_d = rd_last ? '0 : rd_idx_q + IdxW'(1);

`ifdef ARRAY_FEEDER_SUM_EN
  logic signed [31:0] sum_q;
  logic               sum_phase_q;

  // Running wrapped sum of the frame; the first word of a frame restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (in_xfer) begin
      sum_q <= (wr_idx_q == '0) ? bus_io.src_in : sum_q + bus_io.src_in;
    end
  end

  // The checksum is one extra beat after arr[DEPTH-1]; rd_idx stays in range meanwhile.
  assign last_word = sum_phase_q;
  assign next_word = rd_last ? sum_q : arr_q[rd_idx_d];
`else
  assign last_word = rd_last;
  assign next_word = arr_q[rd_idx_d];
`endif

  // Frame storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      arr_q[wr_idx_q] <= bus_io.src_in;
    end
  end

  // FILL/DRAIN sequencer with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFill;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      src_notify_q <= 1'b1;
      m_notify_q   <= 1'b0;
      m_out_q      <= '0;
`ifdef ARRAY_FEEDER_SUM_EN
      sum_phase_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StFill: begin
          if (in_xfer) begin
            if (wr_idx_q == LastIdx) begin
              wr_idx_q     <= '0;
              state_q      <= StDrain;
              src_notify_q <= 1'b0;
              m_notify_q   <= 1'b1;
              // arr[0] was written at least one cycle earlier since DEPTH >= 2.
              m_out_q      <= arr_q[0];
            end else begin
              wr_idx_q <= wr_idx_q + IdxW'(1);
            end
          end
        end
        StDrain: begin
          if (out_xfer) begin
            if (last_word) begin
              rd_idx_q     <= '0;
              state_q      <= StFill;
              m_notify_q   <= 1'b0;
              src_notify_q <= 1'b1;
`ifdef ARRAY_FEEDER_SUM_EN
              sum_phase_q  <= 1'b0;
`endif
            end else begin
              rd_idx_q <= rd_idx_d;
              m_out_q  <= next_word;
`ifdef ARRAY_FEEDER_SUM_EN
              sum_phase_q <= rd_last;
`endif
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign bus_io.src_in_notify = src_notify_q;
  assign bus_io.m_out_notify  = m_notify_q;
  assign bus_io.m_out         = m_out_q;

endmodule

// File: tb/tb_array_feeder.sv
// Directed bench for array_feeder (DEPTH=4). Inputs change and outputs are sampled 1 time
// unit after each rising edge. Checksum words are expected only when ARRAY_FEEDER_SUM_EN
// is defined.
module tb_array_feeder;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  array_feeder_if bus ();

  array_feeder #(
    .DEPTH (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push four words with continuous sync; FILL must accept every one of them.
  task automatic feed(input logic [31:0] w [4]);
    for (int i = 0; i < 4; i++) begin
      check_eq("feed_src_notify", {31'd0, bus.src_in_notify}, 32'd1);
      check_eq("feed_m_notify", {31'd0, bus.m_out_notify}, 32'd0);
      bus.src_in      = w[i];
      bus.src_in_sync = 1'b1;
      tick();
    end
    bus.src_in_sync = 1'b0;
  endtask

  // Take the whole frame with continuous sync, first word visible right after the last input.
  task automatic drain(input logic [31:0] w [4], input logic [31:0] sum);
    logic [31:0] exp [$];
    exp = {};
    for (int i = 0; i < 4; i++) exp.push_back(w[i]);
`ifdef ARRAY_FEEDER_SUM_EN
    exp.push_back(sum);
`else
    if (sum == 32'hdead_beef) exp.push_back(sum);  // never used; keeps sum referenced
`endif
    bus.m_out_sync = 1'b1;
    foreach (exp[i]) begin
      check_eq("drain_m_notify", {31'd0, bus.m_out_notify}, 32'd1);
      check_eq("drain_src_notify", {31'd0, bus.src_in_notify}, 32'd0);
      check_eq("drain_m_out", bus.m_out, exp[i]);
      tick();
    end
    bus.m_out_sync = 1'b0;
    check_eq("end_m_notify", {31'd0, bus.m_out_notify}, 32'd0);
    check_eq("end_src_notify", {31'd0, bus.src_in_notify}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f_basic [4];
    logic [31:0] f_big   [4];
    logic [31:0] f_small [4];
    logic [31:0] f_mid   [4];
    logic [31:0] f_wrap  [4];
    f_basic = '{32'd10, 32'd20, 32'd30, 32'hFFFF_FFFB};
    f_big   = '{32'd100, 32'd200, 32'd300, 32'd400};
    f_small = '{32'd1, 32'd2, 32'd3, 32'd4};
    f_mid   = '{32'd5, 32'd6, 32'd7, 32'd8};
    f_wrap  = '{32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0};
    n_cmp = 0;
    n_err = 0;

    bus.src_in      = '0;
    bus.src_in_sync = 1'b0;
    bus.m_out_sync  = 1'b0;

    // Reset held for three cycles.
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_src_notify", {31'd0, bus.src_in_notify}, 32'd1);
    check_eq("rst_m_notify", {31'd0, bus.m_out_notify}, 32'd0);
    check_eq("rst_m_out", bus.m_out, 32'd0);
    rst = 1'b0;
    tick();

    // Basic frame.
    feed(f_basic);
    drain(f_basic, 32'd55);

    // Backpressure in DRAIN, with an ignored src_in_sync carrying junk.
    feed(f_basic);
    bus.src_in      = 32'd999;
    bus.src_in_sync = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_m_out", bus.m_out, 32'd10);
      check_eq("bp_m_notify", {31'd0, bus.m_out_notify}, 32'd1);
      check_eq("bp_src_notify", {31'd0, bus.src_in_notify}, 32'd0);
    end
    bus.src_in_sync = 1'b0;
    drain(f_basic, 32'd55);

    // m_out_sync asserted during FILL must be ignored.
    bus.m_out_sync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("fill_idle_m_notify", {31'd0, bus.m_out_notify}, 32'd0);
    end
    feed(f_big);
    drain(f_big, 32'd1000);

    // Reset after two of four inputs discards the partial frame.
    bus.src_in      = 32'd77;
    bus.src_in_sync = 1'b1;
    tick();
    bus.src_in = 32'd88;
    tick();
    bus.src_in_sync = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("midfill_rst_src_notify", {31'd0, bus.src_in_notify}, 32'd1);
    check_eq("midfill_rst_m_notify", {31'd0, bus.m_out_notify}, 32'd0);
    rst = 1'b0;
    tick();
    feed(f_small);
    drain(f_small, 32'd10);

    // Reset during DRAIN after one output.
    feed(f_mid);
    bus.m_out_sync = 1'b1;
    tick();
    bus.m_out_sync = 1'b0;
    check_eq("middrain_second_word", bus.m_out, 32'd6);
    rst = 1'b1;
    tick();
    check_eq("middrain_rst_m_out", bus.m_out, 32'd0);
    check_eq("middrain_rst_m_notify", {31'd0, bus.m_out_notify}, 32'd0);
    check_eq("middrain_rst_src_notify", {31'd0, bus.src_in_notify}, 32'd1);
    rst = 1'b0;
    tick();
    feed(f_small);
    drain(f_small, 32'd10);

    // Wrapped checksum.
    feed(f_wrap);
    drain(f_wrap, 32'h8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
